mips_muldiv_unit: RTL and testbench
===================================

// Module: mips_muldiv_unit
// PURPOSE
//   Iterative multiply/divide unit owning the MIPS HI/LO registers; a parametrised
//   successor to the single-cycle ALU product/quotient path. Executes MULT/MULTU/
//   DIV/DIVU one bit per cycle (radix-2 shift-add / restoring divide), handles
//   MTHI/MTLO, and exposes a start/busy/done handshake so the core can stall MFHI/MFLO.
// PARAMETERS
//   WIDTH  32  operand/HI/LO width (>=4); iteration count = WIDTH
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high reset
//   start        in   1      request; sampled only while busy==0
//   op           in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others = no-op
//   a            in   WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
//   b            in   WIDTH  rt operand (divisor / multiplier)
//   busy         out  1      operation in progress; new start ignored
//   done         out  1      one-cycle pulse; hi/lo hold the new result in this cycle
//   div_by_zero  out  1      pulses with done when DIV/DIVU had b==0
//   hi           out  WIDTH  HI register
//   lo           out  WIDTH  LO register
// BEHAVIOUR
//   - Clocking: one clock, clk; reset is synchronous and active-high. All state changes on the rising edge.
//   - Reset: state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0. Reset during an
//     op aborts it; no done pulse; hi/lo=0 the cycle after.
//   - States: IDLE -> MUL|DIV (WIDTH iteration cycles) -> FIX (1 cycle) -> IDLE.
//   - Start edge (IDLE, start=1, op MULT..DIVU, not DIV-by-zero): latch |a|, |b| (magnitudes for
//     signed ops, raw for unsigned), record result signs; busy=1 from the next cycle.
//   - Iteration: one bit per cycle, counter 0..WIDTH-1; 2*WIDTH-bit accumulator; all arithmetic
//     unsigned on magnitudes.
//   - FIX: MULT negates 2*WIDTH product if sign(a)^sign(b). DIV: quotient negated if
//     sign(a)^sign(b); remainder takes sign of dividend. hi/lo written, done=1, busy=0.
//   - Latency: start in cycle 0 -> done=1 in cycle WIDTH+2 (34 for WIDTH=32); busy=1 cycles 1..WIDTH+1.
//   - Results: MULT/MULTU {hi,lo}=product. DIV/DIVU lo=quotient, hi=remainder.
//   - Divide by zero (b==0): no iteration; next cycle done=1, div_by_zero=1, hi=a, lo=all-ones.
//   - Signed overflow DIV(-2^(WIDTH-1), -1): lo=-2^(WIDTH-1), hi=0 (natural result; no flag).
//   - MTHI/MTLO: busy never asserts; hi (or lo) <= a at the start edge; other register unchanged;
//     done pulses next cycle.
//   - Unused op codes: no state change, no done.
//   - start while busy=1: ignored (no latch, no queue). Start in the done cycle is accepted
//     (back-to-back; state already IDLE).
//   - a/b may change after the start edge without effect. hi/lo hold between completions;
//     hi/lo are not written during iterations.
// TESTING (WIDTH=32 unless stated)
//   1. MULT a=0xFFFFFFFD, b=7
//      -> done in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high cycles 1..33.
//   2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//      Then back-to-back MULTU 3*5, start in the done cycle -> hi=0, lo=15.
//   3. DIV a=0xFFFFFFF9(-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//      DIVU a=7, b=2 -> lo=3, hi=1.
//   4. DIV a=5, b=0 -> done cycle 1, div_by_zero=1, hi=5, lo=0xFFFFFFFF.
//      DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
//   5. Start MULT 6*7, assert start/op=MTHI a=9 at iteration 5 -> ignored; result hi=0, lo=42.
//      Start DIVU, reset at iteration 10 -> next cycle busy=0, hi=lo=0, no done.
//      A following MULTU 2*3 gives lo=6.
//   6. MTLO a=0x1234 -> lo=0x1234 next cycle, hi unchanged, busy never 1, done pulses once.
//      Repeat test 1 with WIDTH=16 (a=0xFFFD) -> hi=0xFFFF, lo=0xFFEB, done cycle 18.

Source files
------------

// File: rtl/mips_muldiv_unit_if.sv
// Core-side bundle for the iterative multiply/divide unit: request operands,
// handshake flags and the architectural HI/LO registers.
interface mips_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: radix-2 shift-add multiply,
// restoring divide on operand magnitudes, sign fix-up in a final cycle.
module mips_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    mips_muldiv_unit_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [WIDTH-1:0] acc_hi, acc_hi_nxt;
    logic [WIDTH-1:0] acc_lo, acc_lo_nxt;
    logic [WIDTH-1:0] mag, mag_nxt;
    logic             neg_q, neg_q_nxt;
    logic             neg_r, neg_r_nxt;
    logic             is_div, is_div_nxt;
    logic             busy_nxt, done_nxt, dbz_nxt;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;

    logic             signed_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [PW-1:0]    prod, prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    // Operand magnitudes and per-iteration datapath
    always_comb begin
        signed_op = ~bus.op[0];
        a_neg     = signed_op & bus.a[WIDTH-1];
        b_neg     = signed_op & bus.b[WIDTH-1];
        a_mag     = a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
        b_mag     = b_neg ? (~bus.b + WIDTH'(1)) : bus.b;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag} : (WIDTH + 1)'(0));
        div_sh    = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_sh >= {1'b0, mag};
        div_diff  = div_sh[WIDTH-1:0] - mag;
        prod      = {acc_hi, acc_lo};
        prod_fix  = neg_q ? (~prod + PW'(1)) : prod;
        quot_fix  = neg_q ? (~acc_lo + WIDTH'(1)) : acc_lo;
        rem_fix   = neg_r ? (~acc_hi + WIDTH'(1)) : acc_hi;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        acc_hi_nxt = acc_hi;
        acc_lo_nxt = acc_lo;
        mag_nxt    = mag;
        neg_q_nxt  = neg_q;
        neg_r_nxt  = neg_r;
        is_div_nxt = is_div;
        busy_nxt   = bus.busy;
        done_nxt   = 1'b0;
        dbz_nxt    = 1'b0;
        hi_nxt     = bus.hi;
        lo_nxt     = bus.lo;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            mag_nxt    = a_mag;
                            acc_hi_nxt = '0;
                            acc_lo_nxt = b_mag;
                            neg_q_nxt  = a_neg ^ b_neg;
                            neg_r_nxt  = 1'b0;
                            is_div_nxt = 1'b0;
                            count_nxt  = '0;
                            busy_nxt   = 1'b1;
                            state_nxt  = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (bus.b == '0) begin
                                hi_nxt   = bus.a;
                                lo_nxt   = '1;
                                done_nxt = 1'b1;
                                dbz_nxt  = 1'b1;
                            end else begin
                                mag_nxt    = b_mag;
                                acc_hi_nxt = '0;
                                acc_lo_nxt = a_mag;
                                neg_q_nxt  = a_neg ^ b_neg;
                                neg_r_nxt  = a_neg;
                                is_div_nxt = 1'b1;
                                count_nxt  = '0;
                                busy_nxt   = 1'b1;
                                state_nxt  = DIV;
                            end
                        end
                        OP_MTHI: begin
                            hi_nxt   = bus.a;
                            done_nxt = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_nxt   = bus.a;
                            done_nxt = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                {acc_hi_nxt, acc_lo_nxt} = {mul_sum, acc_lo[WIDTH-1:1]};
                count_nxt = count + CW'(1);
                if (count == CW'(WIDTH - 1)) begin
                    count_nxt = '0;
                    state_nxt = FIX;
                end
            end
            DIV: begin
                acc_hi_nxt = div_ge ? div_diff : div_sh[WIDTH-1:0];
                acc_lo_nxt = {acc_lo[WIDTH-2:0], div_ge};
                count_nxt  = count + CW'(1);
                if (count == CW'(WIDTH - 1)) begin
                    count_nxt = '0;
                    state_nxt = FIX;
                end
            end
            FIX: begin
                if (is_div) begin
                    hi_nxt = rem_fix;
                    lo_nxt = quot_fix;
                end else begin
                    {hi_nxt, lo_nxt} = prod_fix;
                end
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            count           <= '0;
            acc_hi          <= '0;
            acc_lo          <= '0;
            mag             <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            is_div          <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.hi          <= '0;
            bus.lo          <= '0;
        end else begin
            state           <= state_nxt;
            count           <= count_nxt;
            acc_hi          <= acc_hi_nxt;
            acc_lo          <= acc_lo_nxt;
            mag             <= mag_nxt;
            neg_q           <= neg_q_nxt;
            neg_r           <= neg_r_nxt;
            is_div          <= is_div_nxt;
            bus.busy        <= busy_nxt;
            bus.done        <= done_nxt;
            bus.div_by_zero <= dbz_nxt;
            bus.hi          <= hi_nxt;
            bus.lo          <= lo_nxt;
        end
    end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: vector table on a 32-bit instance plus
// hand-written sequences for back-to-back, busy-ignore, reset-abort and 16-bit width.
module tb_mips_muldiv_unit;
    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mips_muldiv_unit_if #(.WIDTH(32)) b32 ();
    mips_muldiv_unit_if #(.WIDTH(16)) b16 ();

    mips_muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    mips_muldiv_unit #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(b16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int limit, output int lat);
        lat = 0;
        for (int n = 1; n <= limit && lat == 0; n++) begin
            @(negedge clk);
            if (n == 1) b32.start = 1'b0;
            if (b32.done) lat = n;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          lat, ndone, nbusy, ncyc;
        logic [31:0] rhi, rlo;
        logic        rdbz;
        lat = 0; ndone = 0; nbusy = 0; rdbz = 1'b0;
        rhi = '0; rlo = '0;
        ncyc = (v.lat == 0) ? 40 : v.lat + 3;
        @(negedge clk);
        b32.start = 1'b1; b32.op = v.op; b32.a = v.a; b32.b = v.b;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            if (n == 1) begin
                b32.start = 1'b0;
                b32.a     = $urandom;
                b32.b     = $urandom;
            end
            if (b32.busy) nbusy++;
            if (b32.done) begin
                ndone++;
                if (lat == 0) begin
                    lat = n; rhi = b32.hi; rlo = b32.lo; rdbz = b32.div_by_zero;
                end
            end
        end
        if (v.lat == 0) begin
            rhi = b32.hi; rlo = b32.lo;
        end
        check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.lat));
        check($sformatf("v%0d_done_count", idx), 64'(ndone), (v.lat == 0) ? 64'd0 : 64'd1);
        check($sformatf("v%0d_busy_cycles", idx), 64'(nbusy), (v.lat > 1) ? 64'(v.lat - 1) : 64'd0);
        check($sformatf("v%0d_hi", idx), 64'(rhi), 64'(v.hi));
        check($sformatf("v%0d_lo", idx), 64'(rlo), 64'(v.lo));
        check($sformatf("v%0d_dbz", idx), 64'(rdbz), 64'(v.dbz));
    endtask

    initial begin
        vec_t vecs[15];
        int   lat, ndone;
        logic [31:0] rhi, rlo;

        checks = 0; failures = 0;
        vecs[0]  = '{MULT,  32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
        vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
        vecs[2]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
        vecs[3]  = '{MULT,  32'h6,        32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 34};
        vecs[4]  = '{DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
        vecs[5]  = '{DIVU,  32'h7,        32'h2,        32'h1,        32'h3,        1'b0, 34};
        vecs[6]  = '{DIV,   32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 1'b0, 34};
        vecs[7]  = '{DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 1'b0, 34};
        vecs[8]  = '{DIV,   32'h5,        32'h0,        32'h5,        32'hFFFFFFFF, 1'b1, 1};
        vecs[9]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 34};
        vecs[10] = '{MTHI,  32'hABCD,     32'h5,        32'hABCD,     32'h80000000, 1'b0, 1};
        vecs[11] = '{MTLO,  32'h1234,     32'h5,        32'hABCD,     32'h1234,     1'b0, 1};
        vecs[12] = '{3'b110, 32'h1,       32'h1,        32'hABCD,     32'h1234,     1'b0, 0};
        vecs[13] = '{DIVU,  32'h9,        32'h0,        32'h9,        32'hFFFFFFFF, 1'b1, 1};
        vecs[14] = '{3'b111, 32'h2,       32'h3,        32'h9,        32'hFFFFFFFF, 1'b0, 0};

        b32.start = 1'b0; b32.op = '0; b32.a = '0; b32.b = '0;
        b16.start = 1'b0; b16.op = '0; b16.a = '0; b16.b = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(b32.busy), 64'd0);
        check("reset_done", 64'(b32.done), 64'd0);
        check("reset_dbz", 64'(b32.div_by_zero), 64'd0);
        check("reset_hi", 64'(b32.hi), 64'd0);
        check("reset_lo", 64'(b32.lo), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // Back-to-back: second start issued in the done cycle of the first
        @(negedge clk);
        b32.start = 1'b1; b32.op = MULTU; b32.a = 32'hFFFFFFFF; b32.b = 32'hFFFFFFFF;
        wait_done(40, lat);
        check("b2b_first_latency", 64'(lat), 64'd34);
        check("b2b_first_hi", 64'(b32.hi), 64'hFFFFFFFE);
        b32.start = 1'b1; b32.op = MULTU; b32.a = 32'd3; b32.b = 32'd5;
        @(negedge clk);
        b32.start = 1'b0;
        check("b2b_second_busy", 64'(b32.busy), 64'd1);
        check("b2b_second_nodone", 64'(b32.done), 64'd0);
        lat = 0;
        for (int n = 2; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            if (b32.done) lat = n;
        end
        check("b2b_second_latency", 64'(lat), 64'd34);
        check("b2b_second_hi", 64'(b32.hi), 64'd0);
        check("b2b_second_lo", 64'(b32.lo), 64'd15);

        // MTHI request during iteration 5 must be dropped
        @(negedge clk);
        b32.start = 1'b1; b32.op = MULT; b32.a = 32'd6; b32.b = 32'd7;
        lat = 0; ndone = 0; rhi = '0; rlo = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) b32.start = 1'b0;
            if (n == 6) begin b32.start = 1'b1; b32.op = MTHI; b32.a = 32'd9; end
            if (n == 7) b32.start = 1'b0;
            if (b32.done) begin
                ndone++;
                if (lat == 0) begin lat = n; rhi = b32.hi; rlo = b32.lo; end
            end
        end
        check("ignore_latency", 64'(lat), 64'd34);
        check("ignore_done_count", 64'(ndone), 64'd1);
        check("ignore_hi", 64'(rhi), 64'd0);
        check("ignore_lo", 64'(rlo), 64'd42);

        // Reset in iteration 10 of a DIVU aborts it
        @(negedge clk);
        b32.start = 1'b1; b32.op = DIVU; b32.a = 32'd100; b32.b = 32'd7;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            if (n == 1) b32.start = 1'b0;
        end
        check("abort_busy_before", 64'(b32.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(b32.busy), 64'd0);
        check("abort_done", 64'(b32.done), 64'd0);
        check("abort_hi", 64'(b32.hi), 64'd0);
        check("abort_lo", 64'(b32.lo), 64'd0);
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (b32.done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        run_vec('{MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 34}, 100);

        // 16-bit instance: MULT -3 * 7
        @(negedge clk);
        b16.start = 1'b1; b16.op = MULT; b16.a = 16'hFFFD; b16.b = 16'h0007;
        lat = 0; ndone = 0; rhi = '0; rlo = '0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) begin b16.start = 1'b0; b16.a = 16'h5555; b16.b = 16'hAAAA; end
            if (b16.done) begin
                ndone++;
                if (lat == 0) begin lat = n; rhi = 32'(b16.hi); rlo = 32'(b16.lo); end
            end
        end
        check("w16_latency", 64'(lat), 64'd18);
        check("w16_done_count", 64'(ndone), 64'd1);
        check("w16_hi", 64'(rhi), 64'hFFFF);
        check("w16_lo", 64'(rlo), 64'hFFEB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
